pc_unit: RTL and testbench

- Program-counter stage directly downstream of the ALU branch/condition FSM.
- Consumes the FSM's PC-latch strobe and branch-taken control bit.
- Computes and holds the instruction address presented to instruction memory.
- Exports the current PC, the fall-through address (PC+1) and status flags for the decode and regfile stages.

---
 rtl/pc_unit.sv | 138 +++++++++++++
 tb/tb_pc_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//
// Program-counter stage that sits just after the ALU branch/condition FSM.
// It holds the instruction address presented to instruction memory. It
// advances that address once per rising transition of the FSM's PC-latch
// strobe. The new address is one of:
//   - the fall-through address (PC+1),
//   - a PC-relative branch target (PC+1+offset),
//   - an absolute jump target.
// A decoded halt parks the unit until the next reset.
//
// All state changes on the falling edge of clka. Reset is asynchronous and
// active-low.
//
// Ports:
//   clka                 in   system clock (state updates on negedge)
//   reset_n_in           in   asynchronous active-low reset
//   pc_latch_clkedge_in  in   PC-latch level; a 0->1 transition requests an update
//   pc_ctl_0_in          in   branch-taken bit, sampled on the update edge
//   br_offset_in         in   signed PC-relative branch offset [OFFSET_W]
//   jmp_in               in   absolute jump request
//   jmp_target_in        in   absolute jump target [ADDR_W]
//   halt_in              in   halt instruction decoded
//   pc_out               out  current instruction address [ADDR_W]
//   npc_out              out  pc_out+1 (link / fall-through value) [ADDR_W]
//   pc_valid_out         out  pc_out is a valid fetch address
//   halted_out           out  unit is halted
//   wrap_out             out  one-cycle pulse: last update wrapped the address space
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int                ADDR_W    = 8,
    parameter int                OFFSET_W  = 6,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic                clka,
    input  logic                reset_n_in,
    input  logic                pc_latch_clkedge_in,
    input  logic                pc_ctl_0_in,
    input  logic [OFFSET_W-1:0] br_offset_in,
    input  logic                jmp_in,
    input  logic [ADDR_W-1:0]   jmp_target_in,
    input  logic                halt_in,
    output logic [ADDR_W-1:0]   pc_out,
    output logic [ADDR_W-1:0]   npc_out,
    output logic                pc_valid_out,
    output logic                halted_out,
    output logic                wrap_out
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_valid;
    logic                r_halted;
    logic                r_wrap;
    logic                r_latQ;

    logic                w_update;
    logic [ADDR_W:0]     w_offsetExt;
    logic [ADDR_W:0]     w_incSum;
    logic [ADDR_W:0]     w_brSum;

    // Only a low-to-high step of the strobe counts. The history bit resets
    // to 1, so a strobe that is already high at reset release is not
    // mistaken for a fresh request.
    assign w_update = pc_latch_clkedge_in & ~r_latQ;

    // All sums are one bit wider than the PC. The extra bit is set on an
    // upward carry past 2^ADDR_W. For a negative offset it is also set when
    // the result borrows below zero: the true result then lies in
    // [-2^OFFSET_W, -1], which has the top bit set in ADDR_W+1 two's
    // complement. Either way, bit ADDR_W is the wrap flag.
    assign w_offsetExt = {{(ADDR_W + 1 - OFFSET_W){br_offset_in[OFFSET_W-1]}}, br_offset_in};
    assign w_incSum    = {1'b0, r_pc} + (ADDR_W + 1)'(1);
    assign w_brSum     = w_incSum + w_offsetExt;

    // Main state register.
    // BOOT takes one edge to raise pc_valid.
    // RUN applies at most one update per strobe edge, in priority order:
    // halt, then jump, then branch, then increment.
    // HALT only tracks the strobe history, so its outputs stay frozen
    // until reset.
    always_ff @(negedge clka or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state  <= ST_BOOT;
            r_pc     <= RESET_VEC;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_wrap   <= 1'b0;
            r_latQ   <= 1'b1;
        end else begin
            r_latQ <= pc_latch_clkedge_in;
            r_wrap <= 1'b0;
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                    r_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (w_update) begin
                        if (halt_in) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                            r_valid  <= 1'b0;
                        end else if (jmp_in) begin
                            r_pc <= jmp_target_in;
                        end else if (pc_ctl_0_in) begin
                            r_pc   <= w_brSum[ADDR_W-1:0];
                            r_wrap <= w_brSum[ADDR_W];
                        end else begin
                            r_pc   <= w_incSum[ADDR_W-1:0];
                            r_wrap <= w_incSum[ADDR_W];
                        end
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    assign pc_out       = r_pc;
    assign npc_out      = r_pc + ADDR_W'(1);
    assign pc_valid_out = r_valid;
    assign halted_out   = r_halted;
    assign wrap_out     = r_wrap;

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
//
// Directed testbench for pc_unit.
//
// Each stimulus step does the following:
//   - drives the inputs just after a rising clka edge;
//   - pushes the hand-computed expected outputs onto a queue.
// The DUT updates on the following falling edge. A monitor process pops one
// entry at every rising edge and compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    localparam int ADDR_W   = 8;
    localparam int OFFSET_W = 6;

    logic                clka;
    logic                reset_n_in;
    logic                pc_latch_clkedge_in;
    logic                pc_ctl_0_in;
    logic [OFFSET_W-1:0] br_offset_in;
    logic                jmp_in;
    logic [ADDR_W-1:0]   jmp_target_in;
    logic                halt_in;
    logic [ADDR_W-1:0]   pc_out;
    logic [ADDR_W-1:0]   npc_out;
    logic                pc_valid_out;
    logic                halted_out;
    logic                wrap_out;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic              valid;
        logic              halted;
        logic              wrap;
        string             name;
    } exp_t;

    exp_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;

    pc_unit #(
        .ADDR_W   (ADDR_W),
        .OFFSET_W (OFFSET_W),
        .RESET_VEC(8'h00)
    ) dut (
        .clka               (clka),
        .reset_n_in         (reset_n_in),
        .pc_latch_clkedge_in(pc_latch_clkedge_in),
        .pc_ctl_0_in        (pc_ctl_0_in),
        .br_offset_in       (br_offset_in),
        .jmp_in             (jmp_in),
        .jmp_target_in      (jmp_target_in),
        .halt_in            (halt_in),
        .pc_out             (pc_out),
        .npc_out            (npc_out),
        .pc_valid_out       (pc_valid_out),
        .halted_out         (halted_out),
        .wrap_out           (wrap_out)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Compare every output against one expected record.
    task automatic checkOutput(input exp_t e);
        logic [ADDR_W-1:0] expNpc;
        expNpc = e.pc + 8'd1;
        vectors++;
        if (pc_out !== e.pc) begin
            miscompares++;
            $display("[TB] FAIL %s pc_out: got %02h expected %02h", e.name, pc_out, e.pc);
        end
        if (npc_out !== expNpc) begin
            miscompares++;
            $display("[TB] FAIL %s npc_out: got %02h expected %02h", e.name, npc_out, expNpc);
        end
        if (pc_valid_out !== e.valid) begin
            miscompares++;
            $display("[TB] FAIL %s pc_valid_out: got %b expected %b", e.name, pc_valid_out, e.valid);
        end
        if (halted_out !== e.halted) begin
            miscompares++;
            $display("[TB] FAIL %s halted_out: got %b expected %b", e.name, halted_out, e.halted);
        end
        if (wrap_out !== e.wrap) begin
            miscompares++;
            $display("[TB] FAIL %s wrap_out: got %b expected %b", e.name, wrap_out, e.wrap);
        end
    endtask

    // Monitor: outputs settle on the falling edge, so they are sampled on
    // the rising edge. Each step pushed one record for this edge.
    initial begin
        forever begin
            @(posedge clka);
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    // One clock of stimulus plus the outputs expected after the next
    // falling edge.
    task automatic applyStimulus(
        input logic              rstN,
        input logic              strobe,
        input logic              ctl,
        input logic [5:0]        off,
        input logic              jmp,
        input logic [7:0]        tgt,
        input logic              halt,
        input logic [7:0]        ePc,
        input logic              eValid,
        input logic              eHalted,
        input logic              eWrap,
        input string             name
    );
        exp_t e;
        @(posedge clka);
        #1;
        reset_n_in          = rstN;
        pc_latch_clkedge_in = strobe;
        pc_ctl_0_in         = ctl;
        br_offset_in        = off;
        jmp_in              = jmp;
        jmp_target_in       = tgt;
        halt_in             = halt;
        e.pc     = ePc;
        e.valid  = eValid;
        e.halted = eHalted;
        e.wrap   = eWrap;
        e.name   = name;
        expQ.push_back(e);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t immediate;
        reset_n_in          = 1'b0;
        pc_latch_clkedge_in = 1'b0;
        pc_ctl_0_in         = 1'b0;
        br_offset_in        = '0;
        jmp_in              = 1'b0;
        jmp_target_in       = '0;
        halt_in             = 1'b0;

        //             rst str ctl off    jmp tgt    hlt  pc     v  h  w
        applyStimulus(0, 0, 0, 6'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, "reset0");
        applyStimulus(0, 0, 0, 6'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, "reset1");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'h00, 1, 0, 0, "boot");
        applyStimulus(1, 1, 0, 6'h00, 0, 8'h00, 0, 8'h01, 1, 0, 0, "inc1");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'h01, 1, 0, 0, "hold1");
        applyStimulus(1, 1, 0, 6'h00, 0, 8'h00, 0, 8'h02, 1, 0, 0, "inc2");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'h02, 1, 0, 0, "hold2");
        // Negative branch without borrow: 0x10 + 1 - 4 = 0x0D.
        applyStimulus(1, 1, 0, 6'h00, 1, 8'h10, 0, 8'h10, 1, 0, 0, "jmp10");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'h10, 1, 0, 0, "hold10");
        applyStimulus(1, 1, 1, 6'h3C, 0, 8'h00, 0, 8'h0D, 1, 0, 0, "brNeg4");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'h0D, 1, 0, 0, "hold0D");
        // Positive branch carrying past the top: 0xF0 + 1 + 31 = 0x110.
        applyStimulus(1, 1, 0, 6'h00, 1, 8'hF0, 0, 8'hF0, 1, 0, 0, "jmpF0");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'hF0, 1, 0, 0, "holdF0");
        applyStimulus(1, 1, 1, 6'h1F, 0, 8'h00, 0, 8'h10, 1, 0, 1, "brPosWrap");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'h10, 1, 0, 0, "wrapClr1");
        // Negative branch borrowing below zero: 0x02 + 1 - 32 = -29 = 0xE3.
        applyStimulus(1, 1, 0, 6'h00, 1, 8'h02, 0, 8'h02, 1, 0, 0, "jmp02");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'h02, 1, 0, 0, "hold02");
        applyStimulus(1, 1, 1, 6'h20, 0, 8'h00, 0, 8'hE3, 1, 0, 1, "brBorrow");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'hE3, 1, 0, 0, "wrapClr2");
        // A jump beats a taken branch that would have wrapped, and never wraps.
        applyStimulus(1, 1, 1, 6'h1F, 1, 8'h05, 0, 8'h05, 1, 0, 0, "jmpNoWrap");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'h05, 1, 0, 0, "hold05");
        // Plain increment at the top of the address space.
        applyStimulus(1, 1, 0, 6'h00, 1, 8'hFF, 0, 8'hFF, 1, 0, 0, "jmpFF");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'hFF, 1, 0, 0, "holdFF");
        applyStimulus(1, 1, 0, 6'h00, 0, 8'h00, 0, 8'h00, 1, 0, 1, "incWrap");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'h00, 1, 0, 0, "wrapClr3");
        // A strobe held high for five cycles produces a single update.
        applyStimulus(1, 1, 0, 6'h00, 1, 8'h20, 0, 8'h20, 1, 0, 0, "jmp20");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'h20, 1, 0, 0, "hold20");
        applyStimulus(1, 1, 0, 6'h00, 0, 8'h00, 0, 8'h21, 1, 0, 0, "long1");
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 1, 1, 6'h05, 1, 8'h77, 0, 8'h21, 1, 0, 0, "longHeld");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'h21, 1, 0, 0, "longDone");
        applyStimulus(1, 1, 1, 6'h3C, 1, 8'h80, 0, 8'h80, 1, 0, 0, "jmpWins");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'h80, 1, 0, 0, "hold80");
        // Halt or jump requested with no strobe edge is ignored.
        applyStimulus(1, 0, 1, 6'h03, 1, 8'h33, 1, 8'h80, 1, 0, 0, "noEdgeIgnored");
        // Halt at 0x42 wins over a simultaneous jump.
        applyStimulus(1, 1, 0, 6'h00, 1, 8'h42, 0, 8'h42, 1, 0, 0, "jmp42");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'h42, 1, 0, 0, "hold42");
        applyStimulus(1, 1, 0, 6'h00, 1, 8'h99, 1, 8'h42, 0, 1, 0, "halt");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'h42, 0, 1, 0, "halted1");
        applyStimulus(1, 1, 0, 6'h00, 0, 8'h00, 0, 8'h42, 0, 1, 0, "haltedInc");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'h42, 0, 1, 0, "halted2");
        applyStimulus(1, 1, 1, 6'h1F, 0, 8'h00, 0, 8'h42, 0, 1, 0, "haltedBr");
        // Reset pulse leaves HALT.
        applyStimulus(0, 0, 0, 6'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, "haltReset");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'h00, 1, 0, 0, "reboot");
        applyStimulus(1, 1, 0, 6'h00, 0, 8'h00, 0, 8'h01, 1, 0, 0, "postInc");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'h01, 1, 0, 0, "postHold");
        // Reset asserted between clock edges together with a strobe edge.
        applyStimulus(0, 1, 0, 6'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, "midReset");
        #2;
        immediate.pc     = 8'h00;
        immediate.valid  = 1'b0;
        immediate.halted = 1'b0;
        immediate.wrap   = 1'b0;
        immediate.name   = "asyncImmediate";
        checkOutput(immediate);
        applyStimulus(1, 1, 0, 6'h00, 0, 8'h00, 0, 8'h00, 1, 0, 0, "releaseHigh");
        applyStimulus(1, 1, 0, 6'h00, 0, 8'h00, 0, 8'h00, 1, 0, 0, "stillHigh");
        applyStimulus(1, 0, 0, 6'h00, 0, 8'h00, 0, 8'h00, 1, 0, 0, "dropLow");
        applyStimulus(1, 1, 0, 6'h00, 0, 8'h00, 0, 8'h01, 1, 0, 0, "freshEdge");

        // Let the monitor drain the queue, within a bounded number of cycles.
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clka);
        if (expQ.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
